// File: rtl/cpu_mul_shift_seq.sv
// cpu_mul_shift_seq: requester-side sequencer for the CPU multiply cell.
// Accepts MUL and shift/rotate requests and maps each onto cell operands and
// sign/rotate/shift-right controls. It pulses the cell's M then A register
// enables and returns the registered cell result on a response port.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. rsp_valid/rsp_data hold stable until rsp_ready is seen.
// Optional macro CPU_MULSEQ_FASTZERO_EN: MUL by zero and shifts by zero skip
// the cell and answer one cycle after accept.
module cpu_mul_shift_seq #(
  parameter int DATA_W         = 32,
  parameter int SHAMT_W        = 5,
  parameter bit ACCEPT_IN_RESP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] E_src1_mul_cell,
  output logic [DATA_W-1:0] E_src2_mul_cell,
  output logic              E_ctrl_mul_shift_src1_signed,
  output logic              E_ctrl_mul_shift_src2_signed,
  output logic              M_en,
  output logic              A_en,
  output logic              M_mul_cell_rotate,
  output logic              M_mul_cell_shift_right,
  input  logic [DATA_W-1:0] A_mul_cell_result
);

  localparam logic [2:0] OP_MUL = 3'd0;
  localparam logic [2:0] OP_SLL = 3'd1;
  localparam logic [2:0] OP_SRL = 3'd2;
  localparam logic [2:0] OP_SRA = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [2:0] OP_ROR = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_CAPT  = 3'd2,
    S_RESP  = 3'd3,
    S_ZRESP = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                ready;
  logic                accept;
  logic [SHAMT_W-1:0]  n;
  logic [SHAMT_W-1:0]  n_neg;
  logic [DATA_W-1:0]   map_src2;
  logic                map_signa;
  logic                map_rot;
  logic                map_shr;
  logic                illegal;
  logic                fast;
  logic [DATA_W-1:0]   fast_data;
  logic [DATA_W-1:0]   zres_q;

  // Shift amount and its negation mod 32. A right shift by n is a multiply by
  // 2^(32-n) with the high word selected.
  assign n     = req_src2[SHAMT_W-1:0];
  assign n_neg = -n;

  // Map the incoming request onto cell operand B and the cell controls.
  always_comb begin
    map_src2  = req_src2;
    map_signa = 1'b0;
    map_rot   = 1'b0;
    map_shr   = 1'b0;
    illegal   = 1'b0;
    case (req_op)
      OP_MUL: map_src2 = req_src2;
      OP_SLL: map_src2 = DATA_W'(1) << n;
      OP_SRL, OP_SRA: begin
        map_signa = (req_op == OP_SRA);
        if (n != '0) begin
          map_src2 = DATA_W'(1) << n_neg;
          map_shr  = 1'b1;
        end else begin
          map_src2 = DATA_W'(1);
        end
      end
      OP_ROL: begin
        map_src2 = DATA_W'(1) << n;
        map_rot  = 1'b1;
      end
      OP_ROR: begin
        map_src2 = DATA_W'(1) << n_neg;
        map_rot  = 1'b1;
      end
      default: begin
        map_src2 = '0;
        illegal  = 1'b1;
      end
    endcase
  end

  // Decide whether the request bypasses the cell, and with what result.
  always_comb begin
`ifdef CPU_MULSEQ_FASTZERO_EN
    fast      = illegal
              || ((req_op == OP_MUL) && ((req_src1 == '0) || (req_src2 == '0)))
              || ((req_op != OP_MUL) && (n == '0));
    fast_data = (!illegal && (req_op != OP_MUL)) ? req_src1 : '0;
`else
    fast      = illegal;
    fast_data = '0;
`endif
  end

  // Next-state, handshake and enable decode; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    M_en      = 1'b0;
    A_en      = 1'b0;
    case (state_q)
      S_IDLE:  ready = 1'b1;
      S_ISSUE: begin
        M_en    = 1'b1;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        A_en    = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = A_mul_cell_result;
        if (rsp_ready) begin
          state_d = S_IDLE;
          ready   = ACCEPT_IN_RESP;
        end
      end
      S_ZRESP: begin
        rsp_valid = 1'b1;
        rsp_data  = zres_q;
        if (rsp_ready) begin
          state_d = S_IDLE;
          ready   = ACCEPT_IN_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) ready = 1'b0;
    accept = req_valid && ready;
    if (accept) state_d = fast ? S_ZRESP : S_ISSUE;
    if (flush) begin
      state_d   = S_IDLE;
      rsp_valid = 1'b0;
      M_en      = 1'b0;
      A_en      = 1'b0;
    end
  end

  assign req_ready                    = ready;
  assign E_ctrl_mul_shift_src2_signed = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Capture cell operands/controls on a cell-bound accept; they then hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      E_src1_mul_cell              <= '0;
      E_src2_mul_cell              <= '0;
      E_ctrl_mul_shift_src1_signed <= 1'b0;
      M_mul_cell_rotate            <= 1'b0;
      M_mul_cell_shift_right       <= 1'b0;
    end else if (accept && !fast) begin
      E_src1_mul_cell              <= req_src1;
      E_src2_mul_cell              <= map_src2;
      E_ctrl_mul_shift_src1_signed <= map_signa;
      M_mul_cell_rotate            <= map_rot;
      M_mul_cell_shift_right       <= map_shr;
    end
  end

  // Result for requests answered without the cell.
  always_ff @(posedge clk) begin
    if (reset)               zres_q <= '0;
    else if (accept && fast) zres_q <= fast_data;
  end

endmodule

// File: tb/tb_cpu_mul_shift_seq.sv
// Testbench for cpu_mul_shift_seq: models the external multiply cell, drives
// directed and random requests and checks against an arithmetic reference.
module tb_cpu_mul_shift_seq;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2, rsp_data;
  logic [31:0] e_src1, e_src2, cell_res;
  logic        signa, signb, m_en, a_en, rot, shr;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_mul_shift_seq dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .E_src1_mul_cell(e_src1), .E_src2_mul_cell(e_src2),
    .E_ctrl_mul_shift_src1_signed(signa), .E_ctrl_mul_shift_src2_signed(signb),
    .M_en(m_en), .A_en(a_en),
    .M_mul_cell_rotate(rot), .M_mul_cell_shift_right(shr),
    .A_mul_cell_result(cell_res)
  );

  // Multiply cell model: M stage registers operands, A stage registers result.
  logic [31:0] cm_a, cm_b;
  logic        cm_sa, cm_sb;

  function automatic logic [31:0] cell_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb,
                                          input logic r, input logic sr);
    logic [63:0] xa, xb, p;
    xa = {{32{sa & a[31]}}, a};
    xb = {{32{sb & b[31]}}, b};
    p  = xa * xb;
    if (r)       return p[31:0] | p[63:32];
    else if (sr) return p[63:32];
    else         return p[31:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cm_a <= '0; cm_b <= '0; cm_sa <= 1'b0; cm_sb <= 1'b0; cell_res <= '0;
    end else begin
      if (m_en) begin
        cm_a <= e_src1; cm_b <= e_src2; cm_sa <= signa; cm_sb <= signb;
      end
      if (a_en) cell_res <= cell_fn(cm_a, cm_b, cm_sa, cm_sb, rot, shr);
    end
  end

  // Reference result from the operation's arithmetic meaning.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int n;
    n = int'(b[4:0]);
    case (op)
      3'd0:    return a * b;
      3'd1:    return a << n;
      3'd2:    return a >> n;
      3'd3:    return $unsigned($signed(a) >>> n);
      3'd4:    return (a << n) | (a >> (32 - n));
      3'd5:    return (a >> n) | (a << (32 - n));
      default: return 32'd0;
    endcase
  endfunction

  // Whether the request is answered without the cell (one-cycle latency).
  function automatic bit ref_fast(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    if (op > 3'd5) return 1'b1;
`ifdef CPU_MULSEQ_FASTZERO_EN
    if (op == 3'd0) return (a == 0) || (b == 0);
    return b[4:0] == 5'd0;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one request with rsp_ready=1 and observe the whole transaction.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] data,
                        output int men, output int aen, output logic [31:0] e2,
                        output logic sa, output logic r, output logic sr);
    int g;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; rsp_ready = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; men = 0; aen = 0; data = '0; e2 = '0; sa = 1'b0; r = 1'b0; sr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (m_en) begin men++; e2 = e_src2; sa = signa; end
      if (a_en) begin aen++; r = rot; sr = shr; end
      if (rsp_valid) begin data = rsp_data; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_src1 = '0; req_src2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_cmp++; if ({e_src1, e_src2} !== 64'd0) begin n_fail++; $display("FAIL reset_operands: got %h %h want 0 0", e_src1, e_src2); end
    n_cmp++; if ({signa, signb, m_en, a_en, rot, shr} !== 6'd0) begin n_fail++; $display("FAIL reset_controls: got %b want 000000", {signa, signb, m_en, a_en, rot, shr}); end
    reset = 1'b0;
  endtask

  task automatic test_mul;
    int lat, men, aen; logic [31:0] d, e2; logic sa, r, sr;
    run_op(3'd0, 32'd7, 32'd6, lat, d, men, aen, e2, sa, r, sr);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL mul_latency: got %0d want 3", lat); end
    n_cmp++; if (d !== 32'd42) begin n_fail++; $display("FAIL mul_data: got %0d want 42", d); end
    n_cmp++; if (e2 !== 32'd6) begin n_fail++; $display("FAIL mul_e_src2: got %h want 6", e2); end
    n_cmp++; if (men !== 1 || aen !== 1) begin n_fail++; $display("FAIL mul_enables: got M=%0d A=%0d want 1 1", men, aen); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mul_back_idle: got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_shifts;
    int lat, men, aen; logic [31:0] d, e2; logic sa, r, sr;
    run_op(3'd3, 32'h8000_0000, 32'd4, lat, d, men, aen, e2, sa, r, sr);
    n_cmp++; if (e2 !== 32'h1000_0000) begin n_fail++; $display("FAIL sra_e_src2: got %h want 10000000", e2); end
    n_cmp++; if (sa !== 1'b1 || sr !== 1'b1 || r !== 1'b0) begin n_fail++; $display("FAIL sra_ctrl: got sa=%b shr=%b rot=%b want 1 1 0", sa, sr, r); end
    n_cmp++; if (d !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_data: got %h want f8000000", d); end
    run_op(3'd5, 32'h1, 32'd1, lat, d, men, aen, e2, sa, r, sr);
    n_cmp++; if (e2 !== 32'h8000_0000) begin n_fail++; $display("FAIL ror_e_src2: got %h want 80000000", e2); end
    n_cmp++; if (r !== 1'b1 || sr !== 1'b0) begin n_fail++; $display("FAIL ror_ctrl: got rot=%b shr=%b want 1 0", r, sr); end
    n_cmp++; if (d !== 32'h8000_0000) begin n_fail++; $display("FAIL ror_data: got %h want 80000000", d); end
    run_op(3'd2, 32'h1234, 32'hFFFF_FFE0, lat, d, men, aen, e2, sa, r, sr);
    n_cmp++; if (d !== 32'h1234) begin n_fail++; $display("FAIL srl0_data: got %h want 1234", d); end
`ifdef CPU_MULSEQ_FASTZERO_EN
    n_cmp++; if (lat !== 1 || men !== 0) begin n_fail++; $display("FAIL srl0_path: got lat=%0d M=%0d want 1 0", lat, men); end
`else
    n_cmp++; if (e2 !== 32'h1 || sr !== 1'b0) begin n_fail++; $display("FAIL srl0_ctrl: got e2=%h shr=%b want 1 0", e2, sr); end
`endif
  endtask

  task automatic test_illegal_and_zero;
    int lat, men, aen; logic [31:0] d, e2; logic sa, r, sr;
    for (int op = 6; op < 8; op++) begin
      run_op(3'(op), $urandom, $urandom, lat, d, men, aen, e2, sa, r, sr);
      n_cmp++; if (lat !== 1 || d !== 32'd0 || men !== 0 || aen !== 0) begin n_fail++; $display("FAIL illegal_op%0d: got lat=%0d data=%h M=%0d A=%0d want 1 0 0 0", op, lat, d, men, aen); end
    end
    run_op(3'd0, 32'd0, 32'd5, lat, d, men, aen, e2, sa, r, sr);
`ifdef CPU_MULSEQ_FASTZERO_EN
    n_cmp++; if (lat !== 1 || d !== 32'd0 || men !== 0 || aen !== 0) begin n_fail++; $display("FAIL mul_zero_fast: got lat=%0d data=%h M=%0d A=%0d want 1 0 0 0", lat, d, men, aen); end
`else
    n_cmp++; if (lat !== 3 || d !== 32'd0 || men !== 1 || aen !== 1) begin n_fail++; $display("FAIL mul_zero: got lat=%0d data=%h M=%0d A=%0d want 3 0 1 1", lat, d, men, aen); end
`endif
  endtask

  task automatic test_random;
    int lat, men, aen, exp_lat; logic [31:0] d, e2, a, b, exp; logic sa, r, sr; logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) a = '0;
      if ($urandom_range(0, 5) == 0) b[4:0] = 5'd0;
      if (op == 3'd0 && $urandom_range(0, 5) == 0) b = '0;
      exp = ref_result(op, a, b);
      exp_lat = ref_fast(op, a, b) ? 1 : 3;
      run_op(op, a, b, lat, d, men, aen, e2, sa, r, sr);
      n_cmp++; if (d !== exp) begin n_fail++; $display("FAIL rand_data[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, d, exp); end
      n_cmp++; if (lat !== exp_lat || men !== (exp_lat == 3 ? 1 : 0)) begin n_fail++; $display("FAIL rand_timing[%0d] op=%0d: got lat=%0d M=%0d want lat=%0d", i, op, lat, men, exp_lat); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b, a2, b2, held, exp1, exp2;
    int g;
    a = $urandom | 32'h1; b = $urandom | 32'h1;
    a2 = $urandom; b2 = 32'd3;
    exp1 = ref_result(3'd0, a, b);
    exp2 = ref_result(3'd1, a2, b2);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_src1 = a; req_src2 = b; rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (!rsp_valid && g < 10);
    held = rsp_data;
    n_cmp++; if (held !== exp1) begin n_fail++; $display("FAIL bp_data: got %h want %h", held, exp1); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== exp1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b want 1 %h 0", i, rsp_valid, rsp_data, req_ready, exp1); end
    end
    rsp_ready = 1'b1; req_valid = 1'b1; req_op = 3'd1; req_src1 = a2; req_src2 = b2;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_en !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_issue: got M=%b valid=%b want 1 0", m_en, rsp_valid); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== exp2) begin n_fail++; $display("FAIL b2b_data: got valid=%b data=%h want 1 %h", rsp_valid, rsp_data, exp2); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd1; req_src1 = $urandom; req_src2 = 32'd7; rsp_ready = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_en !== 1'b1) begin n_fail++; $display("FAIL flush_issue: got M=%b want 1", m_en); end
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cycle: got ready=%b valid=%b want 0 0", req_ready, rsp_valid); end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got ready=%b want 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_rsp: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_reset_mid_resp;
    int g;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_src1 = $urandom | 32'h1; req_src2 = $urandom | 32'h1; rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (!rsp_valid && g < 10);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach_resp: got %b want 1", rsp_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rsp: got valid=%b data=%h ready=%b want 0 0 1", rsp_valid, rsp_data, req_ready); end
    n_cmp++; if ({e_src1, e_src2} !== 64'd0 || {signa, signb, m_en, a_en, rot, shr} !== 6'd0) begin n_fail++; $display("FAIL rst_mid_cell: got %h %h %b want 0 0 000000", e_src1, e_src2, {signa, signb, m_en, a_en, rot, shr}); end
    reset = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_shifts();
    test_illegal_and_zero();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid_resp();
    test_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
